// File: rtl/cache_defs.sv
// rtl/cache_defs.sv - shared types and defaults for the victim cache
package cache_defs;

  localparam int VC_ENTRIES_DEFAULT = 4;

  typedef enum logic [1:0] {
    VC_IDLE,
    VC_FLUSH_SCAN,
    VC_FLUSH_WAIT,
    VC_FLUSH_DONE
  } type_vc_states_e;

endpackage

// File: rtl/vc_wb_buffer.sv
// rtl/vc_wb_buffer.sv - one-entry write-back register with req/ack handshake
module vc_wb_buffer #(
  parameter int LINE_ADDR_W = 26,
  parameter int LINE_W      = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_i,
  input  logic [LINE_ADDR_W-1:0] load_addr_i,
  input  logic [LINE_W-1:0]      load_data_i,
  input  logic                   ack_i,
  output logic                   valid_o,
  output logic [LINE_ADDR_W-1:0] addr_o,
  output logic [LINE_W-1:0]      data_o
);

  logic                   valid_q, valid_d;
  logic [LINE_ADDR_W-1:0] addr_q, addr_d;
  logic [LINE_W-1:0]      data_q, data_d;

  // Callers only load while the buffer is empty, so load and ack never collide.
  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (load_i) begin
      valid_d = 1'b1;
      addr_d  = load_addr_i;
      data_d  = load_data_i;
    end else if (ack_i && valid_q) begin
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
    end else begin
      valid_q <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    data_q <= data_d;
  end

  assign valid_o = valid_q;
  assign addr_o  = addr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/wb_victim_cache.sv
// rtl/wb_victim_cache.sv - fully-associative victim cache with write-back drain and flush
module wb_victim_cache
  import cache_defs::*;
#(
  parameter int VC_ENTRIES  = VC_ENTRIES_DEFAULT,
  parameter int LINE_ADDR_W = 26,
  parameter int LINE_W      = 128
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   lookup_req_i,
  input  logic [LINE_ADDR_W-1:0] lookup_addr_i,
  output logic                   victim_hit_o,
  output logic [LINE_W-1:0]      victim_line_o,
  output logic                   victim_dirty_o,
  input  logic                   write_from_victim_i,
  input  logic                   write_to_victim_i,
  input  logic [LINE_ADDR_W-1:0] evict_addr_i,
  input  logic [LINE_W-1:0]      evict_line_i,
  input  logic                   evict_dirty_i,
  output logic                   vc_ready_o,
  input  logic                   vc_flush_i,
  output logic                   vc_flush_ack_o,
  output logic                   vc2mem_req_o,
  output logic [LINE_ADDR_W-1:0] vc2mem_addr_o,
  output logic [LINE_W-1:0]      vc2mem_data_o,
  input  logic                   mem2vc_ack_i
);

  localparam int IDX_W = $clog2(VC_ENTRIES);
  typedef logic [IDX_W-1:0] idx_t;

  logic [VC_ENTRIES-1:0]  valid_q, valid_d, dirty_q, dirty_d;
  logic [LINE_ADDR_W-1:0] addr_q [VC_ENTRIES];
  logic [LINE_ADDR_W-1:0] addr_d [VC_ENTRIES];
  logic [LINE_W-1:0]      line_q [VC_ENTRIES];
  logic [LINE_W-1:0]      line_d [VC_ENTRIES];
  idx_t                   rep_ptr_q, rep_ptr_d, flush_idx_q, flush_idx_d;
  type_vc_states_e        state_q, state_d;

  logic                   wbuf_valid;
  logic [LINE_ADDR_W-1:0] wbuf_addr, wb_load_addr;
  logic [LINE_W-1:0]      wbuf_data, wb_load_data;
  logic                   wb_load;

  logic                   idle, hit_entry, wbuf_match, ovw_hit, free_hit, take, ins, new_dirty;
  idx_t                   hit_idx, ovw_idx, free_idx, slot;
  logic [VC_ENTRIES-1:0]  take_mask, free_mask;

  assign idle = (state_q == VC_IDLE);

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    hit_entry = 1'b0;
    hit_idx   = '0;
    ovw_hit   = 1'b0;
    ovw_idx   = '0;
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      if (valid_q[i] && addr_q[i] == lookup_addr_i) begin
        hit_entry = 1'b1;
        hit_idx   = idx_t'(i);
      end
      if (valid_q[i] && addr_q[i] == evict_addr_i) begin
        ovw_hit = 1'b1;
        ovw_idx = idx_t'(i);
      end
    end
  end

  assign wbuf_match     = wbuf_valid && (wbuf_addr == lookup_addr_i);
  assign victim_hit_o   = lookup_req_i && idle && (hit_entry || wbuf_match);
  assign victim_dirty_o = victim_hit_o && (hit_entry ? dirty_q[hit_idx] : 1'b1);
  assign victim_line_o  = hit_entry ? line_q[hit_idx] : wbuf_data;
  assign take           = write_from_victim_i && victim_hit_o && hit_entry;

  always_comb begin
    take_mask = '0;
    if (take) take_mask[hit_idx] = 1'b1;
  end

  assign free_mask = ~valid_q | take_mask;

  always_comb begin
    free_hit = 1'b0;
    free_idx = '0;
    for (int i = VC_ENTRIES - 1; i >= 0; i--) begin
      if (free_mask[i]) begin
        free_hit = 1'b1;
        free_idx = idx_t'(i);
      end
    end
  end

  // Registered state only: an ack in this cycle frees the buffer for the next one.
  assign vc_ready_o = idle && !(wbuf_valid && !(|(~valid_q)) && dirty_q[rep_ptr_q]);
  assign ins        = write_to_victim_i && vc_ready_o;

  always_comb begin
    valid_d      = valid_q;
    dirty_d      = dirty_q;
    addr_d       = addr_q;
    line_d       = line_q;
    rep_ptr_d    = rep_ptr_q;
    flush_idx_d  = flush_idx_q;
    state_d      = state_q;
    wb_load      = 1'b0;
    wb_load_addr = addr_q[rep_ptr_q];
    wb_load_data = line_q[rep_ptr_q];
    slot         = rep_ptr_q;
    new_dirty    = evict_dirty_i;

    if (take) begin
      valid_d[hit_idx] = 1'b0;
      dirty_d[hit_idx] = 1'b0;
    end

    if (ins) begin
      if (ovw_hit) begin
        // Same-address overwrite keeps any pending dirtiness; the old data is superseded.
        slot      = ovw_idx;
        new_dirty = evict_dirty_i || dirty_q[ovw_idx];
      end else if (free_hit) begin
        slot = free_idx;
      end else begin
        slot      = rep_ptr_q;
        rep_ptr_d = rep_ptr_q + 1'b1;
        wb_load   = dirty_q[rep_ptr_q];
      end
      valid_d[slot] = 1'b1;
      dirty_d[slot] = new_dirty;
      addr_d[slot]  = evict_addr_i;
      line_d[slot]  = evict_line_i;
    end

    case (state_q)
      VC_IDLE: begin
        if (vc_flush_i) begin
          state_d     = VC_FLUSH_SCAN;
          flush_idx_d = '0;
        end
      end
      VC_FLUSH_SCAN: begin
        if (!(valid_q[flush_idx_q] && dirty_q[flush_idx_q] && wbuf_valid)) begin
          if (valid_q[flush_idx_q] && dirty_q[flush_idx_q]) begin
            wb_load              = 1'b1;
            wb_load_addr         = addr_q[flush_idx_q];
            wb_load_data         = line_q[flush_idx_q];
            dirty_d[flush_idx_q] = 1'b0;
          end
          if (flush_idx_q == idx_t'(VC_ENTRIES - 1)) state_d = VC_FLUSH_WAIT;
          else flush_idx_d = flush_idx_q + 1'b1;
        end
      end
      VC_FLUSH_WAIT: begin
        if (!wbuf_valid) state_d = VC_FLUSH_DONE;
      end
      default: state_d = VC_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q     <= '0;
      dirty_q     <= '0;
      rep_ptr_q   <= '0;
      flush_idx_q <= '0;
      state_q     <= VC_IDLE;
    end else begin
      valid_q     <= valid_d;
      dirty_q     <= dirty_d;
      rep_ptr_q   <= rep_ptr_d;
      flush_idx_q <= flush_idx_d;
      state_q     <= state_d;
    end
  end

  always_ff @(posedge clk) begin
    addr_q <= addr_d;
    line_q <= line_d;
  end

  assign vc_flush_ack_o = (state_q == VC_FLUSH_DONE);

  vc_wb_buffer #(
    .LINE_ADDR_W(LINE_ADDR_W),
    .LINE_W     (LINE_W)
  ) u_wbuf (
    .clk        (clk),
    .rst        (rst),
    .load_i     (wb_load),
    .load_addr_i(wb_load_addr),
    .load_data_i(wb_load_data),
    .ack_i      (mem2vc_ack_i),
    .valid_o    (wbuf_valid),
    .addr_o     (wbuf_addr),
    .data_o     (wbuf_data)
  );

  assign vc2mem_req_o  = wbuf_valid;
  assign vc2mem_addr_o = wbuf_addr;
  assign vc2mem_data_o = wbuf_data;

endmodule

// File: tb/tb_wb_victim_cache.sv
// tb/tb_wb_victim_cache.sv - self-checking bench for wb_victim_cache
module tb_wb_victim_cache;

  logic         clk, rst;
  logic         lookup_req, write_from, write_to, evict_dirty, vc_flush, mem2vc_ack;
  logic [25:0]  lookup_addr, evict_addr;
  logic [127:0] evict_line;
  logic         victim_hit_o, victim_dirty_o, vc_ready_o, vc_flush_ack_o, vc2mem_req_o;
  logic [127:0] victim_line_o, vc2mem_data_o;
  logic [25:0]  vc2mem_addr_o;

  wb_victim_cache #(.VC_ENTRIES(4), .LINE_ADDR_W(26), .LINE_W(128)) dut (
    .clk(clk), .rst(rst),
    .lookup_req_i(lookup_req), .lookup_addr_i(lookup_addr),
    .victim_hit_o(victim_hit_o), .victim_line_o(victim_line_o), .victim_dirty_o(victim_dirty_o),
    .write_from_victim_i(write_from), .write_to_victim_i(write_to),
    .evict_addr_i(evict_addr), .evict_line_i(evict_line), .evict_dirty_i(evict_dirty),
    .vc_ready_o(vc_ready_o), .vc_flush_i(vc_flush), .vc_flush_ack_o(vc_flush_ack_o),
    .vc2mem_req_o(vc2mem_req_o), .vc2mem_addr_o(vc2mem_addr_o), .vc2mem_data_o(vc2mem_data_o),
    .mem2vc_ack_i(mem2vc_ack)
  );

  typedef struct {
    logic [25:0]  addr;
    logic [127:0] data;
  } wb_t;

  typedef struct {
    bit          ins;
    logic [25:0] addr;
    bit          dirty;
    bit          exp_hit;
    bit          exp_dirty;
    bit          wb_exp;
    logic [25:0] wb_addr;
  } vec_t;

  wb_t  sb[$];
  vec_t tbl[$];
  int   checks = 0, failures = 0, wb_count = 0;
  int   mem_lat = 3;
  bit   mem_hold = 0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [127:0] line_of(input logic [25:0] a);
    return {4{32'hC0DE_0000 ^ {6'h0, a}}};
  endfunction

  function automatic vec_t mk(input bit ins, input logic [25:0] a, input bit d, input bit eh,
                              input bit ed, input bit we, input logic [25:0] wa);
    vec_t v;
    v.ins = ins; v.addr = a; v.dirty = d; v.exp_hit = eh; v.exp_dirty = ed;
    v.wb_exp = we; v.wb_addr = wa;
    return v;
  endfunction

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    lookup_req = 0; write_from = 0; write_to = 0; vc_flush = 0;
  endtask

  task automatic drive_ins(input logic [25:0] a, input bit d);
    write_to = 1; evict_addr = a; evict_line = line_of(a); evict_dirty = d;
  endtask

  task automatic do_reset();
    tick();
    rst = 1;
    tick();
    tick();
    rst = 0;
  endtask

  task automatic ins_line(input logic [25:0] a, input bit d);
    tick();
    drive_ins(a, d);
    #1;
    check("ins_ready", vc_ready_o, 1);
  endtask

  task automatic lookup_chk(input string name, input logic [25:0] a, input bit eh, input bit ed);
    tick();
    lookup_req = 1; lookup_addr = a;
    #1;
    check({name, "_hit"}, victim_hit_o, eh);
    if (eh) begin
      check({name, "_dirty"}, victim_dirty_o, ed);
      check({name, "_line"}, victim_line_o, line_of(a));
    end
  endtask

  // Memory side: acks mem_lat cycles into each request and scores the write-back.
  initial begin
    int  cnt;
    bit  chk_low;
    wb_t w;
    cnt = 0; chk_low = 0; mem2vc_ack = 0;
    forever begin
      @(posedge clk);
      #1;
      if (chk_low) begin
        check("wb_req_fall", vc2mem_req_o, 0);
        chk_low = 0;
      end
      mem2vc_ack = 0;
      if (rst || mem_hold || !vc2mem_req_o) cnt = 0;
      else begin
        cnt++;
        if (cnt >= mem_lat) begin
          cnt = 0; mem2vc_ack = 1; chk_low = 1; wb_count++;
          if (sb.size() == 0) begin
            checks++; failures++;
            $display("FAIL wb_unexpected actual=%0h required=none", vc2mem_addr_o);
          end else begin
            w = sb.pop_front();
            check("wb_addr", vc2mem_addr_o, w.addr);
            check("wb_data", vc2mem_data_o, w.data);
          end
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int  n, wb0, acks;
    bit  got, hits_seen;
    rst = 1; lookup_req = 0; lookup_addr = '0; write_from = 0; write_to = 0;
    evict_addr = '0; evict_line = '0; evict_dirty = 0; vc_flush = 0;

    tbl.push_back(mk(1, 26'h1, 1, 0, 0, 0, 26'h0));
    tbl.push_back(mk(1, 26'h2, 1, 0, 0, 0, 26'h0));
    tbl.push_back(mk(1, 26'h3, 1, 0, 0, 0, 26'h0));
    tbl.push_back(mk(1, 26'h4, 1, 0, 0, 0, 26'h0));
    tbl.push_back(mk(0, 26'h1, 0, 1, 1, 0, 26'h0));
    tbl.push_back(mk(0, 26'h4, 0, 1, 1, 0, 26'h0));
    tbl.push_back(mk(0, 26'h5, 0, 0, 0, 0, 26'h0));
    tbl.push_back(mk(1, 26'h5, 1, 0, 0, 1, 26'h1));
    tbl.push_back(mk(0, 26'h1, 0, 1, 1, 0, 26'h0));
    tbl.push_back(mk(0, 26'h5, 0, 1, 1, 0, 26'h0));
    tbl.push_back(mk(0, 26'h2, 0, 1, 1, 0, 26'h0));
    tbl.push_back(mk(0, 26'h1, 0, 0, 0, 0, 26'h0));

    // Reset values and basic clean insert / take.
    do_reset();
    lookup_req = 1; lookup_addr = 26'h0;
    #1;
    check("rst_hit", victim_hit_o, 0);
    check("rst_dirty", victim_dirty_o, 0);
    check("rst_req", vc2mem_req_o, 0);
    check("rst_flush_ack", vc_flush_ack_o, 0);
    check("rst_ready", vc_ready_o, 1);
    ins_line(26'h100, 0);
    tick();
    lookup_req = 1; lookup_addr = 26'h100; write_from = 1;
    #1;
    check("clean_hit", victim_hit_o, 1);
    check("clean_dirty", victim_dirty_o, 0);
    check("clean_line", victim_line_o, line_of(26'h100));
    lookup_chk("after_take", 26'h100, 0, 0);

    // Table: fill, overflow into the write-back buffer, wbuf hit, ack clears.
    do_reset();
    mem_lat = 3;
    foreach (tbl[i]) begin
      tick();
      lookup_addr = tbl[i].addr;
      if (tbl[i].ins) drive_ins(tbl[i].addr, tbl[i].dirty);
      else lookup_req = 1;
      if (tbl[i].wb_exp) sb.push_back('{tbl[i].wb_addr, line_of(tbl[i].wb_addr)});
      #1;
      if (tbl[i].ins) check($sformatf("tbl%0d_ready", i), vc_ready_o, 1);
      else begin
        check($sformatf("tbl%0d_hit", i), victim_hit_o, tbl[i].exp_hit);
        if (tbl[i].exp_hit) begin
          check($sformatf("tbl%0d_dirty", i), victim_dirty_o, tbl[i].exp_dirty);
          check($sformatf("tbl%0d_line", i), victim_line_o, line_of(tbl[i].addr));
        end
      end
    end

    // Busy buffer with a full dirty array stalls the insert until the ack.
    mem_hold = 1;
    ins_line(26'h6, 1);
    sb.push_back('{26'h2, line_of(26'h2)});
    tick();
    check("busy_req", vc2mem_req_o, 1);
    check("busy_req_addr", vc2mem_addr_o, 26'h2);
    for (int k = 0; k < 3; k++) begin
      drive_ins(26'h7, 1);
      #1;
      check("busy_ready_low", vc_ready_o, 0);
      tick();
    end
    mem_lat = 1; mem_hold = 0;
    got = 0;
    for (int k = 0; k < 8 && !got; k++) begin
      drive_ins(26'h7, 1);
      #1;
      if (vc_ready_o) begin
        got = 1;
        sb.push_back('{26'h3, line_of(26'h3)});
      end
      tick();
    end
    check("busy_accept", got, 1);
    lookup_chk("busy_ins", 26'h7, 1, 1);
    for (int k = 0; k < 4; k++) tick();

    // Flush with two dirty and two clean entries.
    do_reset();
    mem_lat = 2;
    ins_line(26'h10, 1);
    ins_line(26'h11, 0);
    ins_line(26'h12, 1);
    ins_line(26'h13, 0);
    sb.push_back('{26'h10, line_of(26'h10)});
    sb.push_back('{26'h12, line_of(26'h12)});
    wb0 = wb_count;
    tick();
    vc_flush = 1;
    got = 0; hits_seen = 0;
    for (int k = 0; k < 60 && !got; k++) begin
      tick();
      lookup_req = 1; lookup_addr = 26'h11;
      #1;
      if (victim_hit_o) hits_seen = 1;
      if (vc_flush_ack_o) got = 1;
    end
    check("flush_ack", got, 1);
    check("flush_hits_suppressed", hits_seen, 0);
    check("flush_wb_count", wb_count - wb0, 2);
    tick();
    check("flush_ack_pulse", vc_flush_ack_o, 0);
    lookup_chk("fl10", 26'h10, 1, 0);
    lookup_chk("fl11", 26'h11, 1, 0);
    lookup_chk("fl12", 26'h12, 1, 0);
    lookup_chk("fl13", 26'h13, 1, 0);

    // Flush latency with nothing dirty.
    tick();
    vc_flush = 1;
    n = 0; acks = 0;
    for (int k = 0; k < 40 && acks == 0; k++) begin
      tick();
      n++;
      #1;
      if (vc_flush_ack_o) acks = 1;
    end
    check("flush_clean_ack", acks, 1);
    check("flush_clean_latency", n, 6);

    // Reset while a write-back is pending drops it.
    mem_hold = 1;
    ins_line(26'h20, 1);
    ins_line(26'h21, 1);
    ins_line(26'h22, 1);
    ins_line(26'h23, 1);
    ins_line(26'h24, 1);
    tick();
    check("pend_req", vc2mem_req_o, 1);
    check("pend_addr", vc2mem_addr_o, 26'h20);
    rst = 1; lookup_req = 1; lookup_addr = 26'h20;
    @(posedge clk);
    #2;
    check("rst_mid_req", vc2mem_req_o, 0);
    check("rst_mid_hit", victim_hit_o, 0);
    check("rst_mid_ready", vc_ready_o, 1);
    rst = 0; mem_hold = 0; lookup_req = 0;
    for (int k = 0; k < 4; k++) tick();
    check("sb_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_victim_cache.md
# wb_victim_cache

Small fully-associative victim cache beside the write-back data cache. It catches lines evicted by the data-cache controller (`write_to_victim`) and supplies them back on a later miss (`victim_hit` / `write_from_victim`). Dirty lines pushed out of the victim cache drain to data memory through a one-entry write-back buffer. A flush engine drains every dirty entry before the data-cache flush completes.

## Interface
Parameters:
- `VC_ENTRIES`, 4: number of victim entries (power of two, ≥2).
- `LINE_ADDR_W`, 26: line-address width (byte address minus offset bits).
- `LINE_W`, 128: cache line width in bits.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `lookup_req_i`  in  1  lookup valid; held by the data-cache datapath during request processing.
- `lookup_addr_i`  in  LINE_ADDR_W  line address to look up.
- `victim_hit_o`  out  1  lookup hits a valid entry or the write-back buffer.
- `victim_line_o`  out  LINE_W  data of the hitting line.
- `victim_dirty_o`  out  1  dirty bit of the hitting line.
- `write_from_victim_i`  in  1  data cache takes the hitting line; the line leaves the victim cache.
- `write_to_victim_i`  in  1  insert the evicted data-cache line.
- `evict_addr_i`  in  LINE_ADDR_W  address of the line being inserted.
- `evict_line_i`  in  LINE_W  data of the line being inserted.
- `evict_dirty_i`  in  1  dirty bit of the line being inserted.
- `vc_ready_o`  out  1  insertion accepted this cycle; upstream holds `write_to_victim_i` while this is low.
- `vc_flush_i`  in  1  start flush (level; sampled in IDLE).
- `vc_flush_ack_o`  out  1  one-cycle pulse when the flush is complete.
- `vc2mem_req_o`  out  1  write-back request; always a write.
- `vc2mem_addr_o`  out  LINE_ADDR_W  write-back line address.
- `vc2mem_data_o`  out  LINE_W  write-back data.
- `mem2vc_ack_i`  in  1  memory accepted the write-back.

## Operation
- Per entry: `valid`, `dirty`, `addr`, `line`. Replacement is FIFO: pointer `rep_ptr` wraps modulo `VC_ENTRIES`.
- Lookup (combinational):
  - hit = `lookup_req_i` & (valid entry with matching addr, or `wbuf_valid` & `wbuf_addr` match).
  - Hits are forced to 0 while the flush FSM is not in IDLE.
  - If several entries match (illegal), the lowest index wins. An entry match takes priority over a write-back-buffer match.
- `write_from_victim_i` with hit: the matching entry's `valid` is cleared at the edge. A write-back-buffer hit returns the line with dirty=1. That write-back still completes, which is harmless.
- `write_to_victim_i` & `vc_ready_o`, slot choice in this order:
  - a valid entry whose addr matches `evict_addr_i` (overwrite);
  - else the lowest-index invalid entry, counting the entry freed by a same-cycle `write_from_victim_i`;
  - else entry `rep_ptr`, then `rep_ptr` increments.
- Replacing a valid dirty entry copies it into the write-back buffer. Replacing a clean entry drops it.
- `vc_ready_o` = (flush FSM in IDLE) & ~(`wbuf_valid` & no free slot & entry[`rep_ptr`] dirty). It is computed from registered state only, with no same-cycle bypass of `mem2vc_ack_i`.
- Write-back buffer: `vc2mem_req_o` = `wbuf_valid`. Address and data are stable while req is high. `mem2vc_ack_i` clears `wbuf_valid` at the edge.
- Flush FSM states:
  - `VC_IDLE`: on `vc_flush_i` go to `VC_FLUSH_SCAN` with `idx`=0.
  - `VC_FLUSH_SCAN`:
    - entry[idx] valid & dirty & ~`wbuf_valid`: copy it to wbuf, clear its `dirty`, then advance idx.
    - entry[idx] valid & dirty & `wbuf_valid`: wait.
    - otherwise: advance idx.
    - After the last idx, go to `VC_FLUSH_WAIT`.
  - `VC_FLUSH_WAIT`: go to `VC_FLUSH_DONE` once `wbuf_valid`=0.
  - `VC_FLUSH_DONE`: `vc_flush_ack_o`=1, go to `VC_IDLE`.
- Flush leaves entries valid and clean.

## Timing
- Lookup has zero-cycle latency: the hit is valid in the same cycle as `lookup_addr_i`. This matches the controller sampling `victim_hit` in its process-request state.
- Insert and invalidate take effect at the next rising edge. A lookup of the inserted address hits from the following cycle.
- Write-back: req rises the cycle after the dirty replacement and falls the cycle after ack.
- Flush latency with no dirty entries: `VC_ENTRIES`+2 cycles from `vc_flush_i` to the ack pulse.
- Reset values:
  - all `valid`/`dirty`=0, `rep_ptr`=0, `wbuf_valid`=0, FSM=`VC_IDLE`;
  - `victim_hit_o`=0, `victim_dirty_o`=0, `vc2mem_req_o`=0, `vc_flush_ack_o`=0, `vc_ready_o`=1.
- Reset mid-write-back discards the buffer. The memory side treats the dropped req like a kill.
- Full and all clean: insertion never stalls.

## Structure
- The cache_defs package gains the state enum `type_vc_states_e` (`VC_IDLE`, `VC_FLUSH_SCAN`, `VC_FLUSH_WAIT`, `VC_FLUSH_DONE`) and the `VC_ENTRIES` default.
- Sub-module `vc_wb_buffer`: the one-entry write-back register plus the req/ack handshake.
- The entry array, match logic and flush FSM stay in the top module.

## Test plan
- Insert addr 0x100 clean, then look up 0x100 → hit=1, dirty=0, line matches. Assert `write_from_victim_i` → the next lookup of 0x100 misses.
- Insert 5 dirty lines 0x1–0x5 with `VC_ENTRIES`=4 → 0x1 goes to wbuf, `vc2mem_req_o`=1 with addr 0x1. Ack after 3 cycles → req falls the next cycle.
- With wbuf busy and full of dirty lines, assert insert → `vc_ready_o`=0 until the ack edge, then the insert is accepted.
- Lookup 0x1 while 0x1 sits in wbuf → hit=1, dirty=1, data correct.
- Flush with 2 dirty and 2 clean entries, memory acking in 2 cycles → exactly 2 write-backs, then one `vc_flush_ack_o` pulse. All entries remain valid and clean, and hits are suppressed during the flush.
- Assert `rst` while req is pending → req=0 and hit=0 in the next cycle, `vc_ready_o`=1.
